// File: rtl/dk_discrete_mixer.sv
// Final discrete-audio summing stage: per-channel gain through one shared multiplier,
// saturating sum, and a one-step-per-sample master level ramp for click-free mute.
module dk_discrete_mixer #(
  parameter int NUM_INPUTS     = 4,
  parameter int GAIN_FRAC_BITS = 6,
  parameter int CLOCK_RATE     = 1000000,
  parameter int SAMPLE_RATE    = 48000
) (
  input  logic                    clk,
  input  logic                    I_RSTn,
  input  logic                    audio_clk_en,
  input  logic signed [15:0]      inputs [NUM_INPUTS-1:0],
  input  logic [8*NUM_INPUTS-1:0] gains,
  input  logic                    mute,
  output logic signed [15:0]      out,
  output logic                    out_valid,
  output logic                    busy,
  output logic                    overrun
);

  localparam int IW    = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam int AW    = 25 + $clog2(NUM_INPUTS) + 1;
  localparam int SW    = AW + 8;
  localparam int SHIFT = GAIN_FRAC_BITS + 6;
  localparam logic signed [SW-1:0] SAT_MAX = SW'(32767);
  localparam logic signed [SW-1:0] SAT_MIN = SW'(-32768);

  if (NUM_INPUTS < 1 || NUM_INPUTS > 8) begin : g_bad_num_inputs
    $error("dk_discrete_mixer: NUM_INPUTS must be 1..8");
  end
  if (CLOCK_RATE / SAMPLE_RATE < NUM_INPUTS + 3) begin : g_bad_rate
    $error("dk_discrete_mixer: CLOCK_RATE/SAMPLE_RATE must be >= NUM_INPUTS+3");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_ACCUM, ST_SCALE} state_t;

  state_t                 state_q, state_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic signed [AW-1:0]   acc_q, acc_d;
  logic [6:0]             level_q, level_d;
  logic signed [15:0]     samp_q [NUM_INPUTS-1:0];
  logic signed [15:0]     samp_d [NUM_INPUTS-1:0];
  logic [7:0]             gain_q [NUM_INPUTS-1:0];
  logic [7:0]             gain_d [NUM_INPUTS-1:0];
  logic signed [15:0]     out_q, out_d;
  logic                   out_valid_q, out_valid_d;
  logic                   overrun_q, overrun_d;

  logic signed [24:0]     samp_ext, gain_ext, prod;
  logic signed [SW-1:0]   acc_ext, lvl_ext, scaled;
  logic signed [15:0]     sat_val;

  always_comb begin
    // Shared channel multiplier: signed sample times zero-extended unsigned gain
    samp_ext = 25'(samp_q[idx_q]);
    gain_ext = 25'(gain_q[idx_q]);
    prod     = samp_ext * gain_ext;

    acc_ext  = SW'(acc_q);
    lvl_ext  = SW'(level_q);
    scaled   = (acc_ext * lvl_ext) >>> SHIFT;
    if (scaled > SAT_MAX)      sat_val = 16'sh7fff;
    else if (scaled < SAT_MIN) sat_val = -16'sh8000;
    else                       sat_val = scaled[15:0];
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    level_d     = level_q;
    samp_d      = samp_q;
    gain_d      = gain_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    overrun_d   = overrun_q;

    if (audio_clk_en && state_q != ST_IDLE) overrun_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (audio_clk_en) begin
          samp_d = inputs;
          for (int unsigned i = 0; i < NUM_INPUTS; i++) gain_d[i] = gains[8*i +: 8];
          acc_d = '0;
          idx_d = '0;
          if (mute && level_q != 7'd0)        level_d = level_q - 7'd1;
          else if (!mute && level_q != 7'd64) level_d = level_q + 7'd1;
          state_d = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        acc_d = acc_q + AW'(prod);
        idx_d = idx_q + 1'b1;
        if (idx_q == IW'(NUM_INPUTS - 1)) state_d = ST_SCALE;
      end
      ST_SCALE: begin
        out_d       = sat_val;
        out_valid_d = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge I_RSTn) begin
    if (!I_RSTn) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      acc_q       <= '0;
      level_q     <= '0;
      samp_q      <= '{default: '0};
      gain_q      <= '{default: '0};
      out_q       <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      level_q     <= level_d;
      samp_q      <= samp_d;
      gain_q      <= gain_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q != ST_IDLE);
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_dk_discrete_mixer.sv
// Scoreboard bench for dk_discrete_mixer: expected samples are queued at stimulus time
// and a forked monitor pops/compares them on every out_valid.
module tb_dk_discrete_mixer;

  logic               clk;
  logic               rstn;
  logic               en;
  logic signed [15:0] in_s [3:0];
  logic [31:0]        gains;
  logic               mute;
  logic signed [15:0] out;
  logic               out_valid;
  logic               busy;
  logic               overrun;

  int n_checks = 0;
  int n_fail   = 0;
  int n_valid  = 0;
  int expq[$];

  dk_discrete_mixer #(
    .NUM_INPUTS(4),
    .GAIN_FRAC_BITS(6),
    .CLOCK_RATE(1000000),
    .SAMPLE_RATE(48000)
  ) dut (
    .clk(clk),
    .I_RSTn(rstn),
    .audio_clk_en(en),
    .inputs(in_s),
    .gains(gains),
    .mute(mute),
    .out(out),
    .out_valid(out_valid),
    .busy(busy),
    .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic monitor();
    int e;
    forever begin
      @(negedge clk);
      if (out_valid) begin
        n_valid++;
        if (expq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_out_valid: got %0d expected no sample", int'(out));
        end else begin
          e = expq.pop_front();
          chk("sample", int'(out), e);
        end
      end
    end
  endtask

  // Caller sits at a negedge; the tick is sampled at the next posedge.
  task automatic tick(input int gap);
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    repeat (gap - 1) @(negedge clk);
  endtask

  int vbase;

  initial begin
    fork
      monitor();
      begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
      end
    join_none

    rstn  = 1'b0;
    en    = 1'b0;
    mute  = 1'b0;
    in_s  = '{default: '0};
    gains = '0;
    repeat (3) @(negedge clk);
    chk("reset_out", int'(out), 0);
    chk("reset_valid", int'(out_valid), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_overrun", int'(overrun), 0);
    rstn = 1'b1;
    @(negedge clk);

    // Ramp up from silence
    in_s[0] = 16'sd6400;
    gains   = {8'd0, 8'd0, 8'd0, 8'd64};
    for (int k = 1; k <= 70; k++) begin
      expq.push_back(100 * ((k > 64) ? 64 : k));
      tick(21);
    end
    chk("ramp_overrun", int'(overrun), 0);

    // Positive saturation with latency/busy timing
    in_s  = '{default: 16'sd10000};
    gains = {8'd64, 8'd64, 8'd64, 8'd64};
    expq.push_back(32767);
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    chk("busy_after_e0", int'(busy), 1);
    repeat (4) @(negedge clk);
    chk("valid_before_e5", int'(out_valid), 0);
    chk("busy_before_e5", int'(busy), 1);
    @(negedge clk);
    chk("valid_at_e5", int'(out_valid), 1);
    chk("busy_at_e5", int'(busy), 0);
    repeat (15) @(negedge clk);

    in_s = '{default: -16'sd10000};
    expq.push_back(-32768);
    tick(21);

    // Mute ramp down, then back up
    in_s    = '{default: '0};
    in_s[0] = 16'sd6400;
    gains   = {8'd0, 8'd0, 8'd0, 8'd64};
    mute    = 1'b1;
    for (int k = 1; k <= 64; k++) begin
      expq.push_back(6400 - 100 * k);
      tick(21);
    end
    mute = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      expq.push_back(100 * k);
      tick(21);
    end

    // Rounding toward -inf at low levels, and level 0
    mute    = 1'b1;
    in_s[0] = -16'sd100;
    expq.push_back(-4);
    tick(21);
    expq.push_back(-2);
    tick(21);
    in_s  = '{default: 16'sd30000};
    gains = '1;
    expq.push_back(0);
    tick(21);
    mute    = 1'b0;
    in_s    = '{default: '0};
    in_s[0] = 16'sd100;
    gains   = {8'd0, 8'd0, 8'd0, 8'd64};
    expq.push_back(1);
    tick(21);

    // Back-to-back ticks at minimum spacing
    in_s[0] = 16'sd1000;
    expq.push_back(31);
    tick(6);
    expq.push_back(46);
    tick(6);
    expq.push_back(62);
    tick(6);
    repeat (15) @(negedge clk);
    chk("spacing_overrun", int'(overrun), 0);

    // Overrun and input snapshot
    vbase = n_valid;
    expq.push_back(78);
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    en      = 1'b1;
    in_s[0] = 16'sd20000;
    @(negedge clk);
    en = 1'b0;
    repeat (20) @(negedge clk);
    chk("overrun_set", int'(overrun), 1);
    chk("overrun_one_valid", n_valid - vbase, 1);

    // Reset in the middle of a mix
    in_s[0] = 16'sd1000;
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rstn = 1'b0;
    #1;
    chk("rst_mid_out", int'(out), 0);
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_overrun", int'(overrun), 0);
    chk("rst_mid_valid", int'(out_valid), 0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (10) @(negedge clk);
    in_s[0] = 16'sd6400;
    expq.push_back(100);
    tick(21);

    for (int i = 0; i < 100 && expq.size() > 0; i++) @(negedge clk);
    chk("queue_drained", expq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
